// File: rtl/dm_arbiter_if.sv
// Bundle of every signal around the data-memory arbiter: the CPU data port,
// the display/debug read port, the DM port and the stall statistic.
//   slave  : arbiter side (drives stall/rdata/ack/mem_*/stall_cnt)
//   master : environment side (CPU, display reader, DM model)
interface dm_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // CPU data port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    // display / debug reader
    logic          dis_req;
    logic [AW-1:0] dis_addr;
    logic          dis_ack;
    logic [DW-1:0] dis_rdata;
    // data memory
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    // statistics
    logic [15:0]   stall_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dis_req, dis_addr,
        input  mem_dout,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        output dis_ack, dis_rdata,
        output mem_addr, mem_din, mem_we,
        output stall_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dis_req, dis_addr,
        output mem_dout,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        input  dis_ack, dis_rdata,
        input  mem_addr, mem_din, mem_we,
        input  stall_cnt
    );
endinterface

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between the CPU data port and a read-only
// display/debug scanner. CPU has fixed priority; a saturating starvation
// counter forces the display in after MAX_WAIT lost cycles.
// Ports:
//   clk    memory clock, all state on rising edge
//   reset  asynchronous, active-high
//   bus    dm_arbiter_if.slave: CPU port (req/we/addr/wdata -> stall/rdata/rvalid),
//          display port (req/addr -> ack/rdata), DM port (addr/din/we <- dout),
//          stall_cnt (saturating CPU-stall cycle count)
// MAX_WAIT legal range is 1..15 (starvation counter is 4 bits).
module dm_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic           clk,
    input  logic           reset,
    dm_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DIS  = 2'd2
    } owner_e;

    localparam logic [3:0] MW = 4'(MAX_WAIT);

    owner_e        owner;
    logic          dis_eff;

    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic [DW-1:0] dis_rdata_q, dis_rdata_d;
    logic          dis_ack_q, dis_ack_d;
    logic [3:0]    starve_q, starve_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;

    // A request in its ack cycle is already retired; whatever dis_req shows
    // then belongs to the next access and is only looked at next cycle.
    assign dis_eff = bus.dis_req & ~dis_ack_q;

    always_comb begin
        owner = OWN_NONE;
        if (dis_eff && (!bus.cpu_req || starve_q == MW))
            owner = OWN_DIS;
        else if (bus.cpu_req)
            owner = OWN_CPU;
    end

    // Memory mux; write enable only ever comes from the CPU path.
    always_comb begin
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.mem_we   = 1'b0;
        case (owner)
            OWN_CPU: begin
                bus.mem_addr = bus.cpu_addr;
                bus.mem_din  = bus.cpu_wdata;
                bus.mem_we   = bus.cpu_we;
            end
            OWN_DIS: bus.mem_addr = bus.dis_addr;
            default: ;
        endcase
    end

    assign bus.cpu_stall = bus.cpu_req & (owner != OWN_CPU);

    always_comb begin
        cpu_rdata_d  = cpu_rdata_q;
        cpu_rvalid_d = 1'b0;
        if (owner == OWN_CPU && !bus.cpu_we) begin
            cpu_rdata_d  = bus.mem_dout;
            cpu_rvalid_d = 1'b1;
        end

        dis_rdata_d = dis_rdata_q;
        dis_ack_d   = 1'b0;
        if (owner == OWN_DIS) begin
            dis_rdata_d = bus.mem_dout;
            dis_ack_d   = 1'b1;
        end

        // Counts cycles the display wanted the memory but lost.
        if (owner == OWN_DIS || !dis_eff)
            starve_d = '0;
        else if (starve_q >= MW)
            starve_d = MW;
        else
            starve_d = starve_q + 4'd1;

        stall_cnt_d = stall_cnt_q;
        if (bus.cpu_stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dis_rdata_q  <= '0;
            dis_ack_q    <= 1'b0;
            starve_q     <= '0;
            stall_cnt_q  <= '0;
        end else begin
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dis_rdata_q  <= dis_rdata_d;
            dis_ack_q    <= dis_ack_d;
            starve_q     <= starve_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dis_rdata  = dis_rdata_q;
    assign bus.dis_ack    = dis_ack_q;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter (MAX_WAIT=3) with a small combinational-read
// memory model behind the DM port.
module tb_dm_arbiter;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    logic [15:0] mem [0:255];

    dm_arbiter_if #(.AW(16), .DW(16)) bus ();

    dm_arbiter #(.AW(16), .DW(16), .MAX_WAIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_dout = mem[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // inputs change 1ns after the edge; combinational checks 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic req, input logic we, input logic [15:0] a, input logic [15:0] d);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic dis(input logic req, input logic [15:0] a);
        bus.dis_req  = req;
        bus.dis_addr = a;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1;
        cpu(0, 0, 16'h0, 16'h0);
        dis(0, 16'h0);
        #1;
        chk("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        chk("rst_ack",    32'(bus.dis_ack),    32'd0);
        chk("rst_scnt",   32'(bus.stall_cnt),  32'd0);
        chk("rst_we",     32'(bus.mem_we),     32'd0);
        tick();
        reset = 1'b0;

        // CPU only: write then read back
        cpu(1, 1, 16'h0010, 16'hBEEF);
        #1;
        chk("wr_stall", 32'(bus.cpu_stall), 32'd0);
        chk("wr_we",    32'(bus.mem_we),    32'd1);
        chk("wr_addr",  32'(bus.mem_addr),  32'h0010);
        tick();
        chk("wr_norv",  32'(bus.cpu_rvalid), 32'd0);
        cpu(1, 0, 16'h0010, 16'h0);
        #1;
        chk("rd_stall", 32'(bus.cpu_stall), 32'd0);
        tick();
        chk("rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("rd_data",   32'(bus.cpu_rdata),  32'hBEEF);
        cpu(0, 0, 16'h0, 16'h0);
        tick();
        chk("rd_pulse", 32'(bus.cpu_rvalid), 32'd0);
        chk("rd_hold",  32'(bus.cpu_rdata),  32'hBEEF);

        // Display only: single ack even though dis_req stays high in ack cycle
        dis(1, 16'h0010);
        #1;
        chk("d_addr", 32'(bus.mem_addr), 32'h0010);
        chk("d_we",   32'(bus.mem_we),   32'd0);
        tick();
        chk("d_ack",  32'(bus.dis_ack),   32'd1);
        chk("d_data", 32'(bus.dis_rdata), 32'hBEEF);
        chk("d_ign",  32'(bus.mem_addr),  32'h0000);
        tick();
        chk("d_pulse", 32'(bus.dis_ack), 32'd0);
        dis(0, 16'h0);
        tick();

        // Starvation: CPU holds reads, display forced in on cycle 3
        mem[8'h20] = 16'h0A0A;
        cpu(1, 0, 16'h0020, 16'h0);
        dis(1, 16'h0010);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("sv_c%0d_stall", c), 32'(bus.cpu_stall), 32'd0);
            chk($sformatf("sv_c%0d_addr", c),  32'(bus.mem_addr),  32'h0020);
            tick();
        end
        #1;
        chk("sv_c3_stall", 32'(bus.cpu_stall), 32'd1);
        chk("sv_c3_addr",  32'(bus.mem_addr),  32'h0010);
        chk("sv_c3_we",    32'(bus.mem_we),    32'd0);
        tick();
        chk("sv_c4_ack",   32'(bus.dis_ack),    32'd1);
        chk("sv_c4_rv",    32'(bus.cpu_rvalid), 32'd0);
        chk("sv_c4_scnt",  32'(bus.stall_cnt),  32'd1);
        chk("sv_c4_stall", 32'(bus.cpu_stall),  32'd0);
        dis(0, 16'h0);
        tick();
        chk("sv_c5_rv",   32'(bus.cpu_rvalid), 32'd1);
        chk("sv_c5_data", 32'(bus.cpu_rdata),  32'h0A0A);
        cpu(0, 0, 16'h0, 16'h0);
        tick();

        // Contention from idle: CPU writes win, blocked write never reaches DM
        dis(1, 16'h0010);
        for (int c = 0; c < 3; c++) begin
            cpu(1, 1, 16'h0030 + 16'(c), 16'h1230 + 16'(c));
            #1;
            chk($sformatf("ct_c%0d_stall", c), 32'(bus.cpu_stall), 32'd0);
            chk($sformatf("ct_c%0d_we", c),    32'(bus.mem_we),    32'd1);
            tick();
        end
        cpu(1, 1, 16'h0040, 16'hDEAD);
        #1;
        chk("ct_c3_stall", 32'(bus.cpu_stall), 32'd1);
        chk("ct_c3_we",    32'(bus.mem_we),    32'd0);
        chk("ct_c3_din",   32'(bus.mem_din),   32'd0);
        tick();
        chk("ct_nowr",  32'(mem[8'h40]),     32'h0000);
        chk("ct_wr2",   32'(mem[8'h32]),     32'h1232);
        chk("ct_ack",   32'(bus.dis_ack),    32'd1);
        chk("ct_data",  32'(bus.dis_rdata),  32'hBEEF);
        chk("ct_scnt",  32'(bus.stall_cnt),  32'd2);
        dis(0, 16'h0);
        tick();
        chk("ct_late_wr", 32'(mem[8'h40]), 32'hDEAD);

        // Reset in the middle of a read
        cpu(1, 0, 16'h0010, 16'h0);
        tick();
        chk("mr_rv_pre", 32'(bus.cpu_rvalid), 32'd1);
        dis(1, 16'h0010);
        reset = 1'b1;
        #1;
        chk("mr_rv",    32'(bus.cpu_rvalid), 32'd0);
        chk("mr_rdata", 32'(bus.cpu_rdata),  32'd0);
        chk("mr_drd",   32'(bus.dis_rdata),  32'd0);
        chk("mr_scnt",  32'(bus.stall_cnt),  32'd0);
        cpu(0, 0, 16'h0, 16'h0);
        dis(0, 16'h0);
        #1;
        chk("mr_we", 32'(bus.mem_we), 32'd0);
        tick();
        chk("mr_ack", 32'(bus.dis_ack), 32'd0);
        reset = 1'b0;
        tick();

        // Saturation: preload the counter near the top, then keep stalling
        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        cpu(1, 0, 16'h0010, 16'h0);
        dis(1, 16'h0010);
        for (int c = 0; c < 25; c++) tick();
        chk("sat_scnt", 32'(bus.stall_cnt), 32'hFFFF);
        cpu(0, 0, 16'h0, 16'h0);
        dis(0, 16'h0);
        tick();
        chk("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
